// File: rtl/nios2_oci_dct_trace_capture.sv
// rtl/nios2_oci_dct_trace_capture.sv - DCT trace frame capture FIFO with statistics and end-of-test FSM
//
// Purpose: captures {dct_buffer, dct_count} trace frames from the OCI trace packer into a
//   first-word-fall-through FIFO for a host-side reader, keeps running symbol/drop/error
//   statistics, and tracks end of test (RUN -> DRAIN -> DONE).
// Ports:
//   clk, reset_n                   clock, asynchronous active-low reset
//   dct_valid/dct_buffer/dct_count incoming trace frame
//   test_ending, test_has_ended    end-of-test controls
//   rd_ready -> rd_valid/rd_data/rd_count   FWFT read port (head entry)
//   fill_level                     entries held, 0..DEPTH
//   sym_total, drop_count          saturating statistics
//   overflow, count_err            sticky error flags
//   state, done, end_pulse         end-of-test status
module nios2_oci_dct_trace_capture #(
  parameter int DCT_W  = 30,
  parameter int SLOT_W = 2,
  parameter int CNT_W  = 4,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              dct_valid,
  input  logic [DCT_W-1:0]  dct_buffer,
  input  logic [CNT_W-1:0]  dct_count,
  input  logic              test_ending,
  input  logic              test_has_ended,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic [DCT_W-1:0]  rd_data,
  output logic [CNT_W-1:0]  rd_count,
  output logic [ADDR_W:0]   fill_level,
  output logic [31:0]       sym_total,
  output logic [15:0]       drop_count,
  output logic              overflow,
  output logic              count_err,
  output logic [1:0]        state,
  output logic              done,
  output logic              end_pulse
);

  localparam int MAX_SYM = DCT_W / SLOT_W;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_SYM);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [DCT_W+CNT_W-1:0] mem [DEPTH];
  logic [ADDR_W:0]        wr_ptr, rd_ptr;
  logic                   empty, full, pop, qual, push, drop, too_many;
  logic [CNT_W-1:0]       store_cnt;
  logic [32:0]            sym_sum;
  logic [DCT_W+CNT_W-1:0] head;

  // Extra pointer bit distinguishes full from empty when the low bits match.
  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                      (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign fill_level = wr_ptr - rd_ptr;

  assign rd_valid = !empty;
  assign pop      = rd_valid && rd_ready;
  assign head     = mem[rd_ptr[ADDR_W-1:0]];
  // Stale RAM contents are masked so the read port reads zero while empty.
  assign rd_data  = rd_valid ? head[DCT_W+CNT_W-1:CNT_W] : '0;
  assign rd_count = rd_valid ? head[CNT_W-1:0] : '0;

  // Zero-symbol frames never qualify, so they touch neither the FIFO nor the stats.
  assign qual      = dct_valid && (state_q == S_RUN) && (dct_count != '0);
  assign too_many  = dct_count > MAX_CNT;
  assign store_cnt = too_many ? MAX_CNT : dct_count;
  // When full, a same-cycle pop frees the head slot that this write lands in.
  assign push      = qual && (!full || pop);
  assign drop      = qual && full && !pop;
  assign sym_sum   = {1'b0, sym_total} + 33'(store_cnt);

  always_comb begin
    state_d = state_q;
    if (test_has_ended) begin
      state_d = S_DONE;
    end else begin
      case (state_q)
        S_RUN:   if (test_ending) state_d = S_DRAIN;
        S_DRAIN: if (empty) state_d = S_DONE;
        default: state_d = S_DONE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[ADDR_W-1:0]] <= {dct_buffer, store_cnt};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_RUN;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      sym_total  <= '0;
      drop_count <= '0;
      overflow   <= 1'b0;
      count_err  <= 1'b0;
      end_pulse  <= 1'b0;
    end else begin
      state_q   <= state_d;
      end_pulse <= (state_d == S_DONE) && (state_q != S_DONE);
      if (push) begin
        wr_ptr    <= wr_ptr + 1'b1;
        sym_total <= sym_sum[32] ? 32'hFFFF_FFFF : sym_sum[31:0];
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      end
      if (qual && too_many) count_err <= 1'b1;
    end
  end

  assign state = state_q;
  assign done  = (state_q == S_DONE);

endmodule

// File: tb/tb_nios2_oci_dct_trace_capture.sv
// tb/tb_nios2_oci_dct_trace_capture.sv - self-checking bench for nios2_oci_dct_trace_capture
module tb_nios2_oci_dct_trace_capture;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        dct_valid, test_ending, test_has_ended, rd_ready;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        rd_valid, overflow, count_err, done, end_pulse;
  logic [29:0] rd_data;
  logic [3:0]  rd_count;
  logic [4:0]  fill_level;
  logic [31:0] sym_total;
  logic [15:0] drop_count;
  logic [1:0]  state;

  logic        v2;
  logic [27:0] b2;
  logic [3:0]  c2;
  logic        rv2, ov2, ce2, dn2, ep2;
  logic [27:0] rd2;
  logic [3:0]  rc2;
  logic [4:0]  fl2;
  logic [31:0] st2;
  logic [15:0] dc2;
  logic [1:0]  s2;

  int checks = 0;
  int failures = 0;
  logic [33:0] sb[$];

  always #5 clk = ~clk;

  nios2_oci_dct_trace_capture u_dut (
    .clk(clk), .reset_n(reset_n), .dct_valid(dct_valid), .dct_buffer(dct_buffer),
    .dct_count(dct_count), .test_ending(test_ending), .test_has_ended(test_has_ended),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data), .rd_count(rd_count),
    .fill_level(fill_level), .sym_total(sym_total), .drop_count(drop_count),
    .overflow(overflow), .count_err(count_err), .state(state), .done(done),
    .end_pulse(end_pulse)
  );

  nios2_oci_dct_trace_capture #(.DCT_W(28)) u_dut28 (
    .clk(clk), .reset_n(reset_n), .dct_valid(v2), .dct_buffer(b2), .dct_count(c2),
    .test_ending(1'b0), .test_has_ended(1'b0), .rd_ready(1'b0), .rd_valid(rv2),
    .rd_data(rd2), .rd_count(rc2), .fill_level(fl2), .sym_total(st2), .drop_count(dc2),
    .overflow(ov2), .count_err(ce2), .state(s2), .done(dn2), .end_pulse(ep2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    sb.delete();
    step();
    reset_n = 1'b1;
  endtask

  // Drive one frame for one cycle; the model accepts it when nonzero and not full.
  task automatic push(input logic [29:0] d, input logic [3:0] c);
    dct_valid = 1'b1; dct_buffer = d; dct_count = c;
    if (c != 0 && sb.size() < 16) sb.push_back({d, c});
    step();
    dct_valid = 1'b0;
  endtask

  task automatic pop1(input string tag);
    logic [33:0] e = '0;
    if (sb.size() != 0) e = sb.pop_front();
    chk({tag, ".valid"}, 64'(rd_valid), 64'd1);
    chk({tag, ".data"}, 64'(rd_data), 64'(e[33:4]));
    chk({tag, ".count"}, 64'(rd_count), 64'(e[3:0]));
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
  endtask

  initial begin
    logic [29:0] d;
    dct_valid = 0; dct_buffer = '0; dct_count = '0;
    test_ending = 0; test_has_ended = 0; rd_ready = 0;
    v2 = 0; b2 = '0; c2 = '0;
    do_reset();

    chk("rst.fill", 64'(fill_level), 0);
    chk("rst.valid", 64'(rd_valid), 0);
    chk("rst.data", 64'(rd_data), 0);
    chk("rst.stats", {sym_total, drop_count, 14'd0, overflow, count_err}, 0);
    chk("rst.fsm", {state, done, end_pulse}, 0);

    // T1: three frames, no reads, plus a silently discarded zero-count frame
    push(30'h1234_5678, 4'd5);
    push(30'h0abc_def0, 4'd15);
    push(30'h3fff_0001, 4'd1);
    push(30'h2222_2222, 4'd0);
    chk("t1.fill", 64'(fill_level), 3);
    chk("t1.sym", 64'(sym_total), 21);
    chk("t1.head", 64'(rd_data), 64'h1234_5678);
    chk("t1.cnt", 64'(rd_count), 5);
    for (int i = 0; i < 3; i++) pop1("t1.pop");
    chk("t1.empty", 64'(rd_valid), 0);

    // T2: overfill then full push+pop
    for (int i = 0; i < 18; i++) push(30'($urandom), 4'd1);
    chk("t2.fill", 64'(fill_level), 16);
    chk("t2.drop", 64'(drop_count), 2);
    chk("t2.ovf", 64'(overflow), 1);
    chk("t2.sym", 64'(sym_total), 37);
    chk("t2.head", 64'(rd_data), 64'(sb[0][33:4]));
    d = 30'h1555_aaaa;
    void'(sb.pop_front());
    sb.push_back({d, 4'd2});
    dct_valid = 1; dct_buffer = d; dct_count = 4'd2; rd_ready = 1;
    step();
    dct_valid = 0; rd_ready = 0;
    chk("t2.fill_pp", 64'(fill_level), 16);
    chk("t2.drop_pp", 64'(drop_count), 2);
    chk("t2.sym_pp", 64'(sym_total), 39);
    for (int i = 0; i < 16; i++) pop1("t2.pop");
    chk("t2.empty", 64'(fill_level), 0);

    // T3: count clamp on a DCT_W=28 instance (MAX_SYM=14)
    v2 = 1; b2 = 28'h0bad_cafe; c2 = 4'hF;
    step();
    v2 = 0;
    chk("t3.cnt", 64'(rc2), 14);
    chk("t3.err", 64'(ce2), 1);
    chk("t3.data", 64'(rd2), 64'h0bad_cafe);
    chk("t3.sym", 64'(st2), 14);
    chk("t3.main_err", 64'(count_err), 0);

    // T4: drain with reads, frames during DRAIN ignored
    for (int i = 0; i < 4; i++) push(30'(32'h100 + i), 4'(i + 3));
    test_ending = 1;
    step();
    test_ending = 0;
    chk("t4.drain", 64'(state), 1);
    chk("t4.fill", 64'(fill_level), 4);
    dct_valid = 1; dct_buffer = 30'h3333_3333; dct_count = 4'd7;
    for (int i = 0; i < 4; i++) pop1("t4.pop");
    chk("t4.state_still", 64'(state), 1);
    chk("t4.fill0", 64'(fill_level), 0);
    step();
    chk("t4.done", {state, done, end_pulse}, {2'd2, 1'b1, 1'b1});
    step();
    chk("t4.pulse_off", {state, done, end_pulse}, {2'd2, 1'b1, 1'b0});
    dct_valid = 0;
    chk("t4.drop", 64'(drop_count), 2);
    chk("t4.sym", 64'(sym_total), 39 + 18);
    chk("t4.fill_after", 64'(fill_level), 0);
    repeat (3) step();
    chk("t4.no_repeat", 64'(end_pulse), 0);

    // T5: test_has_ended from RUN with 5 entries
    do_reset();
    for (int i = 0; i < 5; i++) push(30'(32'h2000 + 7 * i), 4'(i + 1));
    test_has_ended = 1;
    step();
    test_has_ended = 0;
    chk("t5.done", {state, done, end_pulse}, {2'd2, 1'b1, 1'b1});
    chk("t5.valid", 64'(rd_valid), 1);
    chk("t5.fill", 64'(fill_level), 5);
    dct_valid = 1; dct_buffer = 30'h1; dct_count = 4'd1;
    for (int i = 0; i < 5; i++) pop1("t5.pop");
    dct_valid = 0;
    chk("t5.fill0", 64'(fill_level), 0);
    chk("t5.sym", 64'(sym_total), 15);

    // T6: asynchronous reset mid-drain, then pointer wrap
    do_reset();
    for (int i = 0; i < 7; i++) push(30'($urandom), 4'd4);
    test_ending = 1;
    step();
    test_ending = 0;
    chk("t6.drain", 64'(state), 1);
    #2;
    reset_n = 0;
    #1;
    sb.delete();
    chk("t6.fill", 64'(fill_level), 0);
    chk("t6.valid", 64'(rd_valid), 0);
    chk("t6.state", 64'(state), 0);
    chk("t6.stats", {sym_total, drop_count, 14'd0, overflow, count_err}, 0);
    step();
    reset_n = 1;
    push(30'h0000_0f00, 4'd1);
    for (int i = 1; i <= 40; i++) begin
      d = 30'($urandom);
      chk("t6.wrap_head", 64'(rd_data), 64'(sb[0][33:4]));
      void'(sb.pop_front());
      sb.push_back({d, 4'(i % 15 + 1)});
      dct_valid = 1; dct_buffer = d; dct_count = 4'(i % 15 + 1); rd_ready = 1;
      step();
      dct_valid = 0; rd_ready = 0;
      chk("t6.wrap_fill", 64'(fill_level), 1);
    end
    pop1("t6.last");
    chk("t6.end_empty", 64'(rd_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
